// File: rtl/blink_meter.sv
`default_nettype none
// ============================================================================
// Module      : blink_meter
// Description : Measures the rising-to-rising period of an asynchronous,
//               slowly toggling input in clk cycles. Two-flop synchroniser,
//               rising-edge detect, saturating period counter, one-cycle
//               valid strobe per completed period, overflow and stuck flags.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             level,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             stuck
);

  localparam logic [WIDTH-1:0] C_MAX = '1;
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // Synchroniser chain; s3 only feeds the edge detector.
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;
  logic rise;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             stuck_q, stuck_d;

  // Synchroniser next values; no debounce, a single high sample is an edge.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise = s2_q & ~s3_q;

  // Measurement FSM: first edge arms the counter, later edges report it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = MEAS;
          cnt_d   = C_ONE;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d   = cnt_q;
          overflow_d = (cnt_q == C_MAX);
          valid_d    = 1'b1;
          cnt_d      = C_ONE;
        end else if (cnt_q != C_MAX) begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Registered so that stuck always mirrors the current state/count.
    stuck_d = (state_d == MEAS) && (cnt_d == C_MAX);
  end

  // State and output registers; reset also clears the synchroniser so a
  // high input at deassert is seen as a fresh first edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      stuck_q    <= stuck_d;
    end
  end

  assign level    = s2_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign stuck    = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_meter
// Description : Directed self-checking bench for blink_meter (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blink_meter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             level;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             overflow;
  logic             stuck;

  int total;
  int bad;
  int cyc;
  int v_cyc[$];
  int v_per[$];
  int v_ovf[$];
  int s_rise[$];
  int s_fall[$];
  logic stuck_prev;

  blink_meter #(.WIDTH(WIDTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .level    (level),
    .period   (period),
    .valid    (valid),
    .overflow (overflow),
    .stuck    (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock; sample outputs 1 ns after the edge and log strobes/stuck edges.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_per.push_back(int'(period));
      v_ovf.push_back(int'(overflow));
    end
    if (stuck === 1'b1 && stuck_prev !== 1'b1) s_rise.push_back(cyc);
    if (stuck !== 1'b1 && stuck_prev === 1'b1) s_fall.push_back(cyc);
    stuck_prev = stuck;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  // Square wave; edges land at a random point inside the cycle.
  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      #($urandom_range(0, 7));
      sig_in = 1'b1;
      hold(hi);
      #($urandom_range(0, 7));
      sig_in = 1'b0;
      hold(lo);
    end
  endtask

  task automatic clear_log();
    cyc = 0;
    v_cyc.delete();
    v_per.delete();
    v_ovf.delete();
    s_rise.delete();
    s_fall.delete();
  endtask

  task automatic do_reset(input logic sig_val);
    rst    = 1'b1;
    sig_in = sig_val;
    hold(3);
    rst    = 1'b0;
    clear_log();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},    {31'd0, level},    32'd0);
    check({tag, "_period"},   {28'd0, period},   32'd0);
    check({tag, "_valid"},    {31'd0, valid},    32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_stuck"},    {31'd0, stuck},    32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    cyc        = 0;
    rst        = 1'b1;
    sig_in     = 1'b0;
    stuck_prev = 1'b0;

    // Steady 5/5 square wave: edges sampled at 1,11,..,51; strobes at 13..53.
    do_reset(1'b0);
    check_reset_outputs("rst0");
    wave(5, 5, 6);
    hold(4);
    check("sq_count", v_cyc.size(), 5);
    check("sq_first", v_cyc.size() > 0 ? v_cyc[0] : -1, 13);
    for (int i = 0; i < v_per.size(); i++) begin
      check("sq_period", v_per[i], 10);
      check("sq_ovf", v_ovf[i], 0);
      if (i > 0) check("sq_gap", v_cyc[i] - v_cyc[i-1], 10);
    end
    check("sq_stuck", s_rise.size(), 0);

    // 1 high / 6 low: 4 edges -> 3 strobes of 7.
    do_reset(1'b0);
    wave(1, 6, 4);
    hold(4);
    check("p7_count", v_per.size(), 3);
    for (int i = 0; i < v_per.size(); i++) check("p7_period", v_per[i], 7);

    // 1 high / 1 low: minimum period 2.
    do_reset(1'b0);
    wave(1, 1, 5);
    hold(4);
    check("p2_count", v_per.size(), 4);
    for (int i = 0; i < v_per.size(); i++) begin
      check("p2_period", v_per[i], 2);
      check("p2_ovf", v_ovf[i], 0);
    end

    // Saturation: edges at 1,21,41 then 49. cnt hits 15 at 17 and 37.
    do_reset(1'b0);
    wave(1, 19, 2);
    wave(1, 7, 2);
    hold(4);
    check("sat_count", v_per.size(), 3);
    check("sat_v0_cyc", v_cyc.size() > 0 ? v_cyc[0] : -1, 23);
    check("sat_v0_per", v_per.size() > 0 ? v_per[0] : -1, 15);
    check("sat_v0_ovf", v_ovf.size() > 0 ? v_ovf[0] : -1, 1);
    check("sat_v1_per", v_per.size() > 1 ? v_per[1] : -1, 15);
    check("sat_v2_per", v_per.size() > 2 ? v_per[2] : -1, 8);
    check("sat_v2_ovf", v_ovf.size() > 2 ? v_ovf[2] : -1, 0);
    check("sat_srise_n", s_rise.size(), 2);
    check("sat_srise0", s_rise.size() > 0 ? s_rise[0] : -1, 17);
    check("sat_sfall0", s_fall.size() > 0 ? s_fall[0] : -1, 23);
    check("sat_srise1", s_rise.size() > 1 ? s_rise[1] : -1, 37);
    check("sat_sfall1", s_fall.size() > 1 ? s_fall[1] : -1, 43);

    // Reset mid-measurement: period 12, strobe at 15, rst pulsed at 20.
    do_reset(1'b0);
    sig_in = 1'b1; hold(6);
    sig_in = 1'b0; hold(6);
    sig_in = 1'b1; hold(6);
    sig_in = 1'b0; hold(2);
    check("mid_pre_per", v_per.size() > 0 ? v_per[0] : -1, 12);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    clear_log();
    hold(3);
    wave(6, 6, 2);
    hold(3);
    check("mid_count", v_per.size(), 1);
    check("mid_cyc", v_cyc.size() > 0 ? v_cyc[0] : -1, 18);
    check("mid_per", v_per.size() > 0 ? v_per[0] : -1, 12);

    // Input high across reset deassert: refill rise is the first edge.
    do_reset(1'b1);
    hold(5);
    sig_in = 1'b0; hold(5);
    sig_in = 1'b1; hold(5);
    sig_in = 1'b0; hold(5);
    check("hi_count", v_per.size(), 1);
    check("hi_cyc", v_cyc.size() > 0 ? v_cyc[0] : -1, 13);
    check("hi_per", v_per.size() > 0 ? v_per[0] : -1, 10);

    // Rise during rst is dropped; the refill rise after it is the first edge.
    do_reset(1'b0);
    sig_in = 1'b1;
    hold(2);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    clear_log();
    hold(5);
    sig_in = 1'b0; hold(5);
    sig_in = 1'b1; hold(5);
    sig_in = 1'b0; hold(5);
    check("col_count", v_per.size(), 1);
    check("col_cyc", v_cyc.size() > 0 ? v_cyc[0] : -1, 13);
    check("col_per", v_per.size() > 0 ? v_per[0] : -1, 10);

    // Hold: period 9 strobe at 12, then input idle; stuck at cnt==15 (cyc 26).
    do_reset(1'b0);
    wave(1, 8, 2);
    hold(20);
    check("hold_count", v_per.size(), 1);
    check("hold_per", {28'd0, period}, 32'd9);
    check("hold_ovf", {31'd0, overflow}, 32'd0);
    check("hold_valid", {31'd0, valid}, 32'd0);
    check("hold_level", {31'd0, level}, 32'd0);
    check("hold_stuck", {31'd0, stuck}, 32'd1);
    check("hold_srise", s_rise.size() > 0 ? s_rise[0] : -1, 26);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
